// File: rtl/conv_window_feeder.sv
// Streams raster-order CH-channel pixels in and emits one zero-padded 3x3xCH window per
// pixel position. Windows lag the input by IMG_W+1 pixels, and the tail of each frame is flushed.
module conv_window_feeder #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int CH    = 3,
    parameter int DW    = 8
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   in_valid,
    input  logic [CH*DW-1:0]       in_pixel,
    output logic                   in_ready,
    output logic                   win_valid,
    output logic [CH*9*DW-1:0]     win_act,
    output logic                   win_last
);

    localparam int PW    = CH * DW;
    localparam int AW    = CH * 9 * DW;
    localparam int NPIX  = IMG_W * IMG_H;
    localparam int SRLEN = 2 * IMG_W + 2;
    localparam int NW    = $clog2(NPIX + 1);
    localparam int CW    = $clog2(IMG_W + 1);
    localparam int RW    = $clog2(IMG_H + 1);

    typedef enum logic [1:0] {
        S_FILL   = 2'd0,
        S_STREAM = 2'd1,
        S_FLUSH  = 2'd2
    } state_t;

    state_t          r_state;
    logic [NW-1:0]   r_n;
    logic [CW-1:0]   r_ocol;
    logic [RW-1:0]   r_orow;
    logic            r_win_valid;
    logic            r_win_last;
    logic [AW-1:0]   r_win_act;
    logic [PW-1:0]   r_sr [SRLEN];

    logic            w_accept;
    logic            w_adv;
    logic            w_at_last;
    logic [PW-1:0]   w_new;
    logic [PW-1:0]   w_tap [9];
    logic [8:0]      w_tap_ok;
    logic [AW-1:0]   w_win;
    logic [CW-1:0]   w_ocol_nxt;
    logic [RW-1:0]   w_orow_nxt;

    assign in_ready  = (r_state != S_FLUSH);
    assign win_valid = r_win_valid;
    assign win_act   = r_win_act;
    assign win_last  = r_win_last;

    // Flush cycles advance the pipeline with a dummy pixel; those taps are always bottom-padded.
    assign w_accept  = in_valid && in_ready;
    assign w_adv     = w_accept || (r_state == S_FLUSH);
    assign w_new     = w_accept ? in_pixel : '0;
    assign w_at_last = (r_orow == RW'(IMG_H - 1)) && (r_ocol == CW'(IMG_W - 1));

    assign w_ocol_nxt = (r_ocol == CW'(IMG_W - 1)) ? '0 : r_ocol + CW'(1);
    assign w_orow_nxt = (r_ocol != CW'(IMG_W - 1)) ? r_orow :
                        ((r_orow == RW'(IMG_H - 1)) ? '0 : r_orow + RW'(1));

    // Pixel history: r_sr[i] holds the pixel accepted i+1 advances ago.
    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_sr[0] <= w_new;
            for (int i = 1; i < SRLEN; i++) begin
                r_sr[i] <= r_sr[i-1];
            end
        end
    end

    for (genvar gr = 0; gr < 3; gr++) begin : g_row
        for (genvar gc = 0; gc < 3; gc++) begin : g_col
            localparam int J = (2 - gr) * IMG_W + 2 - gc;
            if (J == 0) begin : g_new
                assign w_tap[gr*3+gc] = w_new;
            end else begin : g_old
                assign w_tap[gr*3+gc] = r_sr[J-1];
            end
        end
    end

    // Padding mask from the window-centre coordinates only, so stale history never leaks.
    always_comb begin
        w_tap_ok = 9'h1ff;
        for (int t = 0; t < 9; t++) begin
            if (((t < 3) && (r_orow == RW'(0))) ||
                ((t >= 6) && (r_orow == RW'(IMG_H - 1))) ||
                ((t % 3 == 0) && (r_ocol == CW'(0))) ||
                ((t % 3 == 2) && (r_ocol == CW'(IMG_W - 1)))) begin
                w_tap_ok[t] = 1'b0;
            end else begin
                w_tap_ok[t] = 1'b1;
            end
        end
    end

    // Pack taps channel-major: channel c, tap t at [c*9*DW + t*DW].
    always_comb begin
        w_win = '0;
        for (int t = 0; t < 9; t++) begin
            for (int c = 0; c < CH; c++) begin
                if (w_tap_ok[t]) begin
                    w_win[c*9*DW + t*DW +: DW] = w_tap[t][c*DW +: DW];
                end else begin
                    w_win[c*9*DW + t*DW +: DW] = '0;
                end
            end
        end
    end

    // Frame control FSM with registered window outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_FILL;
            r_n         <= '0;
            r_ocol      <= '0;
            r_orow      <= '0;
            r_win_valid <= 1'b0;
            r_win_last  <= 1'b0;
            r_win_act   <= '0;
        end else begin
            r_win_valid <= 1'b0;
            r_win_last  <= 1'b0;
            case (r_state)
                S_FILL: begin
                    if (w_accept) begin
                        r_n <= r_n + NW'(1);
                        if (r_n == NW'(IMG_W)) begin
                            r_state <= S_STREAM;
                        end
                    end
                end
                S_STREAM: begin
                    if (w_accept) begin
                        r_win_valid <= 1'b1;
                        r_win_act   <= w_win;
                        r_ocol      <= w_ocol_nxt;
                        r_orow      <= w_orow_nxt;
                        if (r_n == NW'(NPIX - 1)) begin
                            r_n     <= '0;
                            r_state <= S_FLUSH;
                        end else begin
                            r_n <= r_n + NW'(1);
                        end
                    end
                end
                S_FLUSH: begin
                    r_win_valid <= 1'b1;
                    r_win_act   <= w_win;
                    r_ocol      <= w_ocol_nxt;
                    r_orow      <= w_orow_nxt;
                    if (w_at_last) begin
                        r_win_last <= 1'b1;
                        r_state    <= S_FILL;
                    end
                end
                default: begin
                    r_state <= S_FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_window_feeder.sv
// Self-checking bench for conv_window_feeder at a 4x4x3 image; expected windows come from a
// coordinate-based reference model applied to stored frame arrays.
module tb_conv_window_feeder;

    localparam int W    = 4;
    localparam int H    = 4;
    localparam int CH   = 3;
    localparam int DW   = 8;
    localparam int PW   = CH * DW;
    localparam int AW   = CH * 9 * DW;
    localparam int NPIX = W * H;

    logic          clk = 1'b0;
    logic          rstn;
    logic          in_valid;
    logic [PW-1:0] in_pixel;
    logic          in_ready;
    logic          win_valid;
    logic [AW-1:0] win_act;
    logic          win_last;

    int n_checks = 0;
    int n_fail   = 0;

    logic [PW-1:0] frames [2][NPIX];
    logic [AW-1:0] got_win [$];
    bit            got_last [$];
    int            spurious = 0;
    int            fr_acc   = 0;
    int            tick_no  = 0;

    always #5 clk = ~clk;

    conv_window_feeder #(.IMG_W(W), .IMG_H(H), .CH(CH), .DW(DW)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_pixel  (in_pixel),
        .in_ready  (in_ready),
        .win_valid (win_valid),
        .win_act   (win_act),
        .win_last  (win_last)
    );

    function automatic logic [PW-1:0] pat(int r, int c, int off);
        logic [PW-1:0] p;
        for (int ch = 0; ch < CH; ch++) begin
            p[ch*DW +: DW] = DW'(16 * r + 4 * c + ch + 1 + off);
        end
        return p;
    endfunction

    // Reference: tap (kr,kc) is pixel (orow+kr-1, ocol+kc-1) or zero outside the image.
    function automatic logic [AW-1:0] exp_win(int f, int k);
        logic [AW-1:0] w;
        int orow, ocol, r, c;
        w = '0;
        orow = k / W;
        ocol = k % W;
        for (int kr = 0; kr < 3; kr++) begin
            for (int kc = 0; kc < 3; kc++) begin
                r = orow + kr - 1;
                c = ocol + kc - 1;
                if (r >= 0 && r < H && c >= 0 && c < W) begin
                    for (int ch = 0; ch < CH; ch++) begin
                        w[ch*9*DW + (kr*3+kc)*DW +: DW] = frames[f][r*W+c][ch*DW +: DW];
                    end
                end
            end
        end
        return w;
    endfunction

    function automatic logic [DW-1:0] fld(logic [AW-1:0] w, int ch, int t);
        return w[ch*9*DW + t*DW +: DW];
    endfunction

    task automatic fill_pattern(input int f, input int off);
        for (int i = 0; i < NPIX; i++) frames[f][i] = pat(i / W, i % W, off);
    endtask

    task automatic clear_capture();
        got_win.delete();
        got_last.delete();
        spurious = 0;
        fr_acc   = 0;
    endtask

    // One clock: drive inputs, wait for the edge, then capture any window presented.
    task automatic tick(input bit v, input logic [PW-1:0] p, output bit acc);
        in_valid = v;
        in_pixel = p;
        acc = v && in_ready;
        @(posedge clk);
        #1;
        tick_no++;
        if (acc) fr_acc++;
        if (win_valid) begin
            got_win.push_back(win_act);
            got_last.push_back(win_last);
            if (!acc && fr_acc != NPIX) spurious++;
            if (win_last) fr_acc = 0;
        end
    endtask

    task automatic send_frame(input int f, input bit gappy);
        bit acc;
        int n = 0;
        int budget = 0;
        while (n < NPIX && budget < 400) begin
            tick(gappy ? bit'($urandom_range(0, 1)) : 1'b1,
                 (n < NPIX) ? frames[f][n] : PW'($urandom), acc);
            if (acc) n++;
            budget++;
        end
    endtask

    task automatic drain(input int target);
        bit acc;
        int budget = 0;
        while (got_win.size() < target && budget < 40) begin
            tick(1'b0, PW'($urandom), acc);
            budget++;
        end
        repeat (3) tick(1'b0, PW'($urandom), acc);
    endtask

    task automatic check_frame_windows(input string name, input int f, input int base);
        for (int k = 0; k < NPIX && base + k < got_win.size(); k++) begin
            n_checks++;
            if (got_win[base+k] !== exp_win(f, k)) begin
                n_fail++;
                $display("FAIL %s win k=%0d: got %h expected %h", name, k, got_win[base+k], exp_win(f, k));
            end
            n_checks++;
            if (got_last[base+k] !== (k == NPIX - 1)) begin
                n_fail++;
                $display("FAIL %s last k=%0d: got %0b expected %0b", name, k, got_last[base+k], k == NPIX - 1);
            end
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if (win_valid !== 1'b0 || win_last !== 1'b0 || in_ready !== 1'b1 || win_act !== '0) begin
            n_fail++;
            $display("FAIL reset: got valid=%b last=%b ready=%b act=%h expected 0 0 1 0",
                     win_valid, win_last, in_ready, win_act);
        end
    endtask

    task automatic test_single_frame();
        bit acc;
        bit rdy [6];
        bit lst [6];
        int low_run;
        fill_pattern(0, 0);
        clear_capture();
        for (int i = 0; i < NPIX; i++) begin
            tick(1'b1, frames[0][i], acc);
            n_checks++;
            if (acc !== 1'b1) begin
                n_fail++;
                $display("FAIL single accept n=%0d: got %0b expected 1", i, acc);
            end
            n_checks++;
            if (got_win.size() != ((i >= 5) ? i - 4 : 0)) begin
                n_fail++;
                $display("FAIL single count after n=%0d: got %0d expected %0d", i, got_win.size(), (i >= 5) ? i - 4 : 0);
            end
        end
        low_run = (in_ready === 1'b0) ? 1 : 0;
        for (int j = 0; j < 6; j++) begin
            tick(1'b0, PW'($urandom), acc);
            rdy[j] = in_ready;
            lst[j] = win_valid && win_last;
            n_checks++;
            if (got_win.size() != ((j < 4) ? 12 + j : 16)) begin
                n_fail++;
                $display("FAIL flush count j=%0d: got %0d expected %0d", j, got_win.size(), (j < 4) ? 12 + j : 16);
            end
        end
        for (int j = 0; j < 6 && rdy[j] == 1'b0 && low_run > 0; j++) low_run++;
        n_checks++;
        if (low_run != W + 1) begin
            n_fail++;
            $display("FAIL flush ready_low: got %0d expected %0d", low_run, W + 1);
        end
        n_checks++;
        if (lst[4] !== 1'b1 || lst[3] !== 1'b0 || rdy[5] !== 1'b1) begin
            n_fail++;
            $display("FAIL flush last: got last4=%0b last3=%0b ready_after=%0b expected 1 0 1", lst[4], lst[3], rdy[5]);
        end
        check_frame_windows("single", 0, 0);
    endtask

    task automatic test_edges();
        if (got_win.size() == NPIX) begin
            n_checks++;
            if (fld(got_win[0],0,4) !== 8'd1 || fld(got_win[0],0,5) !== 8'd5 || fld(got_win[0],0,7) !== 8'd17 ||
                fld(got_win[0],0,8) !== 8'd21 || got_win[0][111:104] !== 8'd2) begin
                n_fail++;
                $display("FAIL k0 taps: got %h expected centre 1 right 5 below 17 diag 21 ch1 2", got_win[0]);
            end
            n_checks++;
            if ((fld(got_win[0],0,0) | fld(got_win[0],0,1) | fld(got_win[0],0,2) | fld(got_win[0],0,3) | fld(got_win[0],0,6)) !== 8'd0) begin
                n_fail++;
                $display("FAIL k0 pad: got %h expected taps 0-3,6 zero", got_win[0]);
            end
            n_checks++;
            if (fld(got_win[3],0,3) !== 8'd9 || (fld(got_win[3],0,2) | fld(got_win[3],0,5) | fld(got_win[3],0,8)) !== 8'd0) begin
                n_fail++;
                $display("FAIL k3 wrap: got %h expected tap3 9 taps 2,5,8 zero", got_win[3]);
            end
            n_checks++;
            if ((fld(got_win[4],0,0) | fld(got_win[4],0,3) | fld(got_win[4],0,6)) !== 8'd0) begin
                n_fail++;
                $display("FAIL k4 wrap: got %h expected taps 0,3,6 zero", got_win[4]);
            end
            n_checks++;
            if (fld(got_win[15],0,4) !== 8'd61 || fld(got_win[15],0,0) !== 8'd41 ||
                (fld(got_win[15],0,2) | fld(got_win[15],0,5) | fld(got_win[15],0,6) |
                 fld(got_win[15],0,7) | fld(got_win[15],0,8)) !== 8'd0) begin
                n_fail++;
                $display("FAIL k15 taps: got %h expected centre 61 tap0 41 pads zero", got_win[15]);
            end
        end else begin
            n_checks++;
            n_fail++;
            $display("FAIL edges window_count: got %0d expected %0d", got_win.size(), NPIX);
        end
    endtask

    task automatic test_random_gaps();
        for (int it = 0; it < 2; it++) begin
            if (it == 0) fill_pattern(0, 0);
            else for (int i = 0; i < NPIX; i++) frames[0][i] = PW'($urandom);
            clear_capture();
            send_frame(0, 1'b1);
            drain(NPIX);
            n_checks++;
            if (got_win.size() != NPIX || spurious != 0) begin
                n_fail++;
                $display("FAIL gaps it=%0d: got count=%0d spurious=%0d expected %0d 0", it, got_win.size(), spurious, NPIX);
            end
            check_frame_windows("gaps", 0, 0);
        end
    endtask

    task automatic test_back_to_back();
        bit acc;
        int idx = 0;
        int budget = 0;
        int t_last1 = -1;
        int t_acc2 = -1;
        fill_pattern(0, 0);
        fill_pattern(1, 100);
        clear_capture();
        while (idx < 2 * NPIX && budget < 200) begin
            tick(1'b1, frames[idx / NPIX][idx % NPIX], acc);
            if (acc) begin
                if (idx == NPIX) t_acc2 = tick_no;
                idx++;
            end
            if (t_last1 < 0 && win_valid && win_last) t_last1 = tick_no;
            budget++;
        end
        drain(2 * NPIX);
        n_checks++;
        if (got_win.size() != 2 * NPIX || spurious != 0) begin
            n_fail++;
            $display("FAIL b2b count: got %0d spurious=%0d expected %0d 0", got_win.size(), spurious, 2 * NPIX);
        end
        n_checks++;
        if (t_acc2 != t_last1 + 1) begin
            n_fail++;
            $display("FAIL b2b restart: got accept tick %0d expected %0d", t_acc2, t_last1 + 1);
        end
        check_frame_windows("b2b_f1", 0, 0);
        check_frame_windows("b2b_f2", 1, NPIX);
        if (got_win.size() > NPIX) begin
            n_checks++;
            if (fld(got_win[NPIX],0,4) !== 8'd101 ||
                (fld(got_win[NPIX],0,0) | fld(got_win[NPIX],0,1) | fld(got_win[NPIX],0,2) |
                 fld(got_win[NPIX],0,3) | fld(got_win[NPIX],0,6)) !== 8'd0) begin
                n_fail++;
                $display("FAIL b2b f2k0: got %h expected centre 101 top/left zero", got_win[NPIX]);
            end
        end
    endtask

    task automatic test_reset_midframe();
        bit acc;
        for (int i = 0; i < NPIX; i++) frames[0][i] = PW'($urandom) | PW'(1);
        clear_capture();
        for (int i = 0; i < 10; i++) tick(1'b1, frames[0][i], acc);
        #2;
        rstn = 1'b0;
        #1;
        n_checks++;
        if (win_valid !== 1'b0 || win_last !== 1'b0 || in_ready !== 1'b1 || win_act !== '0) begin
            n_fail++;
            $display("FAIL midreset: got valid=%b last=%b ready=%b act=%h expected 0 0 1 0",
                     win_valid, win_last, in_ready, win_act);
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        fill_pattern(0, 0);
        clear_capture();
        send_frame(0, 1'b0);
        drain(NPIX);
        n_checks++;
        if (got_win.size() != NPIX || spurious != 0) begin
            n_fail++;
            $display("FAIL post_reset count: got %0d spurious=%0d expected %0d 0", got_win.size(), spurious, NPIX);
        end
        check_frame_windows("post_reset", 0, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn     = 1'b0;
        in_valid = 1'b0;
        in_pixel = '0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        test_reset();
        test_single_frame();
        test_edges();
        test_random_gaps();
        test_back_to_back();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_window_feeder.md
Name: conv_window_feeder

Overview:
- Streaming producer that drives the 3x3 convolution input interface.
- Accepts a raster-order stream of CH-channel pixels.
- Buffers two image lines plus the current row.
- Emits one zero-padded (pad=1, stride=1) 3x3xCH activation window per output position, packed for a downstream conv layer that has a valid-only input and no backpressure.
- Sits between the frame/pixel source and the first conv layer.

Parameters:
- IMG_W, 8, image width in pixels (>=2)
- IMG_H, 8, image height in pixels (>=2)
- CH, 3, channels per pixel
- DW, 8, bits per channel sample (signed, passed through unmodified)

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- in_valid  in  1  input pixel valid
- in_pixel  in  CH*DW  pixel; channel c at bits [c*DW +: DW]
- in_ready  out  1  feeder can accept a pixel this cycle
- win_valid  out  1  win_act holds a valid window (single-cycle pulse per window)
- win_act  out  CH*9*DW  packed window (216 bits at defaults)
- win_last  out  1  asserted with win_valid on the final window of a frame

Behaviour:
- Clock and reset: clock clk; reset rstn, asynchronous, active-low.
- Reset values:
  - win_valid=0, win_last=0, win_act=0.
  - in_ready=1 (state FILL).
  - All row/column/window counters = 0.
  - Line-buffer RAM contents are not reset.
- Handshake: pixel accepted when in_valid && in_ready. Accepted pixel index n = r*IMG_W + c, with n counting 0..IMG_W*IMG_H-1 per frame.
- Window content for centre index k = orow*IMG_W + ocol:
  - Channel c, tap t = kr*3+kc (kr,kc in 0..2), occupies bits [c*9*DW + t*DW +: DW].
  - That field holds pixel (orow+kr-1, ocol+kc-1) channel c, or 0 if the coordinate is outside the image.
  - Padding is derived from coordinates only. Stale line-buffer data from an earlier frame or from before reset must never appear.
- Windows are emitted strictly in order k=0..IMG_W*IMG_H-1; exactly IMG_W*IMG_H windows per frame.
- States:
  - FILL: in_ready=1, no output. Move to STREAM on the cycle pixel n=IMG_W is accepted.
  - STREAM: in_ready=1. When pixel n=k+IMG_W+1 is accepted, window k is presented on the next cycle (registered, latency 1). Cycles with no acceptance produce no window; gaps are allowed. After pixel n=IMG_W*IMG_H-1 is accepted, go to FLUSH.
  - FLUSH: in_ready=0. One window per consecutive cycle for the remaining IMG_W+1 centres, k=IMG_W*IMG_H-IMG_W-1 .. IMG_W*IMG_H-1. win_last=1 with k=IMG_W*IMG_H-1. Return to FILL in the same cycle the last window is presented.
- FLUSH timing:
  - The first FLUSH window directly follows the last STREAM window with no bubble.
  - in_ready stays low for exactly IMG_W+1 cycles.
  - in_ready=1 in the cycle after win_last is presented.
  - A next-frame pixel may be accepted that cycle, and counters restart from n=0.
- in_ready is a function of registered state only; there is no combinational path from in_valid.
- win_act holds its last value when win_valid=0. Consumers must qualify on win_valid.
- Reset asserted mid-frame or mid-flush: the frame is abandoned, state returns to FILL with the outputs above, and the next accepted pixel is n=0 of a new frame.
- Column wrap: the left/right padding mask uses the column counter, so a window at ocol=IMG_W-1 never contains pixels from column 0 of the next row, and vice versa.

Test Plan:
- Single frame, IMG_W=IMG_H=4, CH=3. p(r,c,ch)=16r+4c+ch+1, continuous in_valid. Required:
  - No win_valid during n=0..4.
  - First window (k=0) the cycle after n=5 is accepted: ch0 tap4=1, tap5=5, tap7=17, tap8=21, taps 0-3 and 6 =0; ch1 tap4 (bits[111:104])=2.
  - 16 windows total.
- Flush, same frame:
  - Window k=10 follows acceptance of n=15.
  - Then in_ready=0 for exactly 5 cycles, with windows k=11..15 back-to-back.
  - k=15: ch0 tap4=61, tap0=41, taps 2,5,6,7,8 =0; win_last=1 only there.
- Random in_valid gaps (~50% duty): window contents and order identical to the gapless run; window count per frame=16; no window emitted in a cycle not preceded by an acceptance (outside FLUSH).
- Back-to-back frames, second frame with values +100: in_valid held high through FLUSH; first pixel of frame 2 accepted the cycle after win_last; frame-2 k=0 has zero top/left taps and is not polluted by frame-1 data.
- Right-edge wrap: k=3 (ocol=3) has taps 2,5,8 =0 and tap3 = p(0,2)=9 (ch0); k=4 has taps 0,3,6 =0.
- Reset: assert rstn low after n=9 of frame 1, release, then send a full frame → outputs reset as specified, and the new frame matches the single-frame reference exactly.
